// File: rtl/shift_reg_ctrl.sv
// Command sequencer for a 4-bit bidirectional shift register: expands hold/shift/load
// commands into per-cycle sel/serial/parallel controls. Optional SHIFT_REG_CTRL_ABORT_EN adds abort/aborted.
//
// state  | meaning
// IDLE   | cmd_ready high, waiting for a command
// RUN    | issuing sel/serial/parallel controls, one register update per cycle
// FINISH | done pulse, controls parked at hold
module shift_reg_ctrl #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 3,
   localparam int FILL_W = 2**CNT_W
) (
   input  logic              clk,
   input  logic              rst,
`ifdef SHIFT_REG_CTRL_ABORT_EN
   input  logic              abort,
   output logic              aborted,
`endif
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [CNT_W-1:0]  cmd_count,
   input  logic [FILL_W-1:0] cmd_fill,
   output logic [1:0]        sel,
   output logic              left_in,
   output logic              right_in,
   output logic [WIDTH-1:0]  parallel_in,
   output logic              busy,
   output logic              done
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_RUN    = 2'd1;
   localparam logic [1:0] S_FINISH = 2'd2;

   localparam logic [1:0] OP_HOLD  = 2'b00;
   localparam logic [1:0] OP_LEFT  = 2'b01;
   localparam logic [1:0] OP_RIGHT = 2'b10;
   localparam logic [1:0] OP_LOAD  = 2'b11;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [1:0]        state_q, state_d;
   logic [1:0]        op_q, op_d;
   logic [FILL_W-1:0] fill_q, fill_d;
   logic [CNT_W-1:0]  idx_q, idx_d;
   logic [CNT_W-1:0]  rem_q, rem_d;
   logic [1:0]        sel_q, sel_d;
   logic              left_q, left_d;
   logic              right_q, right_d;
   logic [WIDTH-1:0]  par_q, par_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              ready_q, ready_d;
   logic              abort_hit;
   logic [CNT_W-1:0]  idx_nxt;

`ifdef SHIFT_REG_CTRL_ABORT_EN
   logic aborted_q, aborted_d;
   assign abort_hit = abort;
`else
   assign abort_hit = 1'b0;
`endif

   assign idx_nxt = idx_q + CNT_ONE;

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      fill_d  = fill_q;
      idx_d   = idx_q;
      rem_d   = rem_q;
      sel_d   = sel_q;
      left_d  = left_q;
      right_d = right_q;
      par_d   = par_q;
      busy_d  = busy_q;
      done_d  = done_q;
      ready_d = ready_q;
      case (state_q)
         S_IDLE: begin
            if (cmd_valid && ready_q) begin
               op_d    = cmd_op;
               fill_d  = cmd_fill;
               idx_d   = '0;
               busy_d  = 1'b1;
               ready_d = 1'b0;
               if (cmd_op == OP_HOLD || (cmd_op != OP_LOAD && cmd_count == '0)) begin
                  state_d = S_FINISH;
                  rem_d   = '0;
                  done_d  = 1'b1;
               end else begin
                  state_d = S_RUN;
                  sel_d   = cmd_op;
                  rem_d   = (cmd_op == OP_LOAD) ? CNT_ONE : cmd_count;
                  left_d  = (cmd_op == OP_LEFT) ? cmd_fill[0] : 1'b0;
                  right_d = (cmd_op == OP_RIGHT) ? cmd_fill[0] : 1'b0;
                  if (cmd_op == OP_LOAD) par_d = cmd_fill[WIDTH-1:0];
               end
            end
         end
         S_RUN: begin
            if (rem_q == CNT_ONE || abort_hit) begin
               state_d = S_FINISH;
               rem_d   = '0;
               sel_d   = OP_HOLD;
               left_d  = 1'b0;
               right_d = 1'b0;
               done_d  = 1'b1;
            end else begin
               idx_d   = idx_nxt;
               rem_d   = rem_q - CNT_ONE;
               left_d  = (op_q == OP_LEFT) ? fill_q[idx_nxt] : 1'b0;
               right_d = (op_q == OP_RIGHT) ? fill_q[idx_nxt] : 1'b0;
            end
         end
         S_FINISH: begin
            state_d = S_IDLE;
            idx_d   = '0;
            rem_d   = '0;
            sel_d   = OP_HOLD;
            left_d  = 1'b0;
            right_d = 1'b0;
            done_d  = 1'b0;
            busy_d  = 1'b0;
            ready_d = 1'b1;
         end
         default: begin
            state_d = S_IDLE;
            sel_d   = OP_HOLD;
            done_d  = 1'b0;
            busy_d  = 1'b0;
            ready_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         op_q    <= OP_HOLD;
         fill_q  <= '0;
         idx_q   <= '0;
         rem_q   <= '0;
         sel_q   <= OP_HOLD;
         left_q  <= 1'b0;
         right_q <= 1'b0;
         par_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         ready_q <= 1'b1;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         fill_q  <= fill_d;
         idx_q   <= idx_d;
         rem_q   <= rem_d;
         sel_q   <= sel_d;
         left_q  <= left_d;
         right_q <= right_d;
         par_q   <= par_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         ready_q <= ready_d;
      end
   end

`ifdef SHIFT_REG_CTRL_ABORT_EN
   // Flags only the RUN->FINISH transition taken because of abort, so it coincides with done.
   always_comb aborted_d = (state_q == S_RUN) && abort;

   always_ff @(posedge clk) begin
      if (rst) aborted_q <= 1'b0;
      else     aborted_q <= aborted_d;
   end

   assign aborted = aborted_q;
`endif

   assign cmd_ready   = ready_q;
   assign sel         = sel_q;
   assign left_in     = left_q;
   assign right_in    = right_q;
   assign parallel_in = par_q;
   assign busy        = busy_q;
   assign done        = done_q;

endmodule

// File: tb/tb_shift_reg_ctrl.sv
// Directed bench for shift_reg_ctrl with a behavioural model of the downstream
// register; define SHIFT_REG_CTRL_ABORT_EN to also exercise abort.
module tb_shift_reg_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_op;
   logic [2:0] cmd_count;
   logic [7:0] cmd_fill;
   logic [1:0] sel;
   logic       left_in;
   logic       right_in;
   logic [3:0] parallel_in;
   logic       busy;
   logic       done;
`ifdef SHIFT_REG_CTRL_ABORT_EN
   logic       abort;
   logic       aborted;
`endif

   int total = 0;
   int bad   = 0;
   logic [3:0] q_model = 4'b0000;

   always #5 clk = ~clk;

   shift_reg_ctrl #(.WIDTH(4), .CNT_W(3)) dut (
      .clk(clk),
      .rst(rst),
`ifdef SHIFT_REG_CTRL_ABORT_EN
      .abort(abort),
      .aborted(aborted),
`endif
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_op(cmd_op),
      .cmd_count(cmd_count),
      .cmd_fill(cmd_fill),
      .sel(sel),
      .left_in(left_in),
      .right_in(right_in),
      .parallel_in(parallel_in),
      .busy(busy),
      .done(done)
   );

   // Downstream register: left_in enters at the MSB end, right_in at the LSB end.
   always @(posedge clk) begin
      case (sel)
         2'b01: q_model <= {left_in, q_model[3:1]};
         2'b10: q_model <= {q_model[2:0], right_in};
         2'b11: q_model <= parallel_in;
         default: q_model <= q_model;
      endcase
   end

   typedef struct {
      logic [1:0] op;
      logic [2:0] cnt;
      logic [7:0] fill;
      int         n;
      logic [3:0] q;
      logic [3:0] par;
   } vec_t;

   vec_t vecs[9];

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, ".sel"}, int'(sel), 0);
      chk({tag, ".done"}, int'(done), 0);
      chk({tag, ".ready"}, int'(cmd_ready), 1);
      chk({tag, ".busy"}, int'(busy), 0);
   endtask

   task automatic run_cmd(input logic [1:0] op, input logic [2:0] cnt, input logic [7:0] fill,
                          input int n, input logic [3:0] exp_q, input logic [3:0] exp_par);
      chk("pre.ready", int'(cmd_ready), 1);
      cmd_valid = 1'b1; cmd_op = op; cmd_count = cnt; cmd_fill = fill;
      @(negedge clk);
      // keep valid high with different fields: must be ignored while busy
      cmd_op = ~op; cmd_count = ~cnt; cmd_fill = ~fill;
      for (int i = 0; i < n; i++) begin
         chk("run.sel", int'(sel), int'(op));
         chk("run.left", int'(left_in), (op == 2'b01) ? int'(fill[i]) : 0);
         chk("run.right", int'(right_in), (op == 2'b10) ? int'(fill[i]) : 0);
         chk("run.par", int'(parallel_in), int'(exp_par));
         chk("run.busy", int'(busy), 1);
         chk("run.ready", int'(cmd_ready), 0);
         chk("run.done", int'(done), 0);
         @(negedge clk);
      end
      cmd_valid = 1'b0;
      chk("fin.done", int'(done), 1);
      chk("fin.sel", int'(sel), 0);
      chk("fin.busy", int'(busy), 1);
      chk("fin.ready", int'(cmd_ready), 0);
      chk("fin.par", int'(parallel_in), int'(exp_par));
`ifdef SHIFT_REG_CTRL_ABORT_EN
      chk("fin.aborted", int'(aborted), 0);
`endif
      @(negedge clk);
      chk("post.ready", int'(cmd_ready), 1);
      chk("post.busy", int'(busy), 0);
      chk("post.done", int'(done), 0);
      chk("post.q", int'(q_model), int'(exp_q));
   endtask

   initial begin
      vecs[0] = '{op: 2'b11, cnt: 3'd0, fill: 8'h0A, n: 1, q: 4'b1010, par: 4'hA};
      vecs[1] = '{op: 2'b11, cnt: 3'd5, fill: 8'h00, n: 1, q: 4'b0000, par: 4'h0};
      vecs[2] = '{op: 2'b01, cnt: 3'd4, fill: 8'b0000_1011, n: 4, q: 4'b1011, par: 4'h0};
      vecs[3] = '{op: 2'b10, cnt: 3'd0, fill: 8'hFF, n: 0, q: 4'b1011, par: 4'h0};
      vecs[4] = '{op: 2'b00, cnt: 3'd5, fill: 8'hFF, n: 0, q: 4'b1011, par: 4'h0};
      vecs[5] = '{op: 2'b10, cnt: 3'd3, fill: 8'b0000_0101, n: 3, q: 4'b1101, par: 4'h0};
      vecs[6] = '{op: 2'b11, cnt: 3'd0, fill: 8'hF5, n: 1, q: 4'b0101, par: 4'h5};
      vecs[7] = '{op: 2'b01, cnt: 3'd7, fill: 8'h55, n: 7, q: 4'b1010, par: 4'h5};
      vecs[8] = '{op: 2'b10, cnt: 3'd1, fill: 8'h00, n: 1, q: 4'b0100, par: 4'h5};

      rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_count = 3'd0; cmd_fill = 8'h00;
`ifdef SHIFT_REG_CTRL_ABORT_EN
      abort = 1'b0;
`endif
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         chk_idle("reset");
         @(negedge clk);
      end
      chk("reset.left", int'(left_in), 0);
      chk("reset.right", int'(right_in), 0);
      chk("reset.par", int'(parallel_in), 0);

      for (int v = 0; v < 9; v++)
         run_cmd(vecs[v].op, vecs[v].cnt, vecs[v].fill, vecs[v].n, vecs[v].q, vecs[v].par);

      // reset in the middle of a shift-right of 5
      cmd_valid = 1'b1; cmd_op = 2'b10; cmd_count = 3'd5; cmd_fill = 8'h1F;
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("rst1.sel", int'(sel), 2);
      chk("rst1.right", int'(right_in), 1);
      @(negedge clk);
      chk("rst2.sel", int'(sel), 2);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk_idle("rstmid");
      chk("rstmid.par", int'(parallel_in), 0);
      chk("rstmid.right", int'(right_in), 0);
      @(negedge clk);
      chk_idle("rstmid2");
      run_cmd(2'b11, 3'd0, 8'h0A, 1, 4'b1010, 4'hA);

`ifdef SHIFT_REG_CTRL_ABORT_EN
      cmd_valid = 1'b1; cmd_op = 2'b01; cmd_count = 3'd6; cmd_fill = 8'h3F;
      @(negedge clk);
      cmd_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("ab.sel", int'(sel), 1);
         chk("ab.aborted_low", int'(aborted), 0);
         if (i == 2) abort = 1'b1;
         @(negedge clk);
      end
      abort = 1'b0;
      chk("ab.sel_end", int'(sel), 0);
      chk("ab.done", int'(done), 1);
      chk("ab.aborted", int'(aborted), 1);
      @(negedge clk);
      chk("ab.ready", int'(cmd_ready), 1);
      chk("ab.aborted_clr", int'(aborted), 0);
      chk("ab.q", int'(q_model), 4'b1111);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk_idle("ab.idle_abort");
      chk("ab.idle_aborted", int'(aborted), 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
